// File: rtl/dvp_pkg.sv
// Shared types and constants for the RGB-to-Bayer DVP camera emulator.
// Used by rgb_to_bayer_dvp and dvp_timing_gen; the colour-bar table serves the BAYER_TPG_EN build.
package dvp_pkg;

  typedef enum logic [2:0] {
    S_VSYNC  = 3'd0,
    S_VBP    = 3'd1,
    S_ACTIVE = 3'd2,
    S_HBLANK = 3'd3,
    S_VFP    = 3'd4
  } dvp_state_e;

  // BGGR phase is {line parity, pixel parity}.
  localparam logic [1:0] PH_B  = 2'b00;
  localparam logic [1:0] PH_GB = 2'b01;
  localparam logic [1:0] PH_GR = 2'b10;
  localparam logic [1:0] PH_R  = 2'b11;

  localparam int NUM_BARS = 8;

  // Bar i lives at bits [24*i +: 24] as RGB888; bar 0 (white) is leftmost.
  localparam logic [NUM_BARS*24-1:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    return BAR_RGB[idx*24 +: 24];
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic [7:0] bayer_pick(input logic [1:0] phase, input logic [7:0] r,
                                            input logic [7:0] g, input logic [7:0] b);
    logic [7:0] s;
    case (phase)
      PH_B:    s = b;
      PH_GB:   s = g;
      PH_GR:   s = g;
      PH_R:    s = r;
      default: s = g;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// DVP frame-timing FSM: vsync, vertical porches, active lines and horizontal blanking.
// Blank periods run off clk alone; active lines advance only on accepted pixels.
module dvp_timing_gen
  import dvp_pkg::*;
#(
  parameter int IM_X   = 1280,
  parameter int IM_Y   = 720,
  parameter int VS_LEN = 8,
  parameter int VBP    = 16,
  parameter int VFP    = 16,
  parameter int HBLANK = 32,
  parameter int XW     = $clog2(IM_X + 1),
  parameter int YW     = $clog2(IM_Y + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  output dvp_state_e    state,
  output logic [XW-1:0] cnt_x,
  output logic [YW-1:0] cnt_y
);

  localparam int BW = $clog2(max4(VS_LEN, VBP, VFP, HBLANK) + 1);

  dvp_state_e    state_q, state_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      S_VSYNC: begin
        if (blank_q == BW'(VS_LEN - 1)) begin
          state_d = S_VBP;
          blank_d = '0;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      S_VBP: begin
        if (blank_q == BW'(VBP - 1)) begin
          state_d = S_ACTIVE;
          blank_d = '0;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      S_ACTIVE: begin
        if (advance) begin
          if (x_q == XW'(IM_X - 1)) begin
            x_d     = '0;
            y_d     = y_q + 1'b1;
            state_d = S_HBLANK;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_HBLANK: begin
        // y already counts the finished line, so y==IM_Y means the last line just ended.
        if (blank_q == BW'(HBLANK - 1)) begin
          blank_d = '0;
          state_d = (y_q == YW'(IM_Y)) ? S_VFP : S_ACTIVE;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      S_VFP: begin
        if (blank_q == BW'(VFP - 1)) begin
          state_d = S_VSYNC;
          blank_d = '0;
          y_d     = '0;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      default: begin
        state_d = S_VSYNC;
        blank_d = '0;
        x_d     = '0;
        y_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_VSYNC;
      blank_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign state = state_q;
  assign cnt_x = x_q;
  assign cnt_y = y_q;

endmodule

// File: rtl/rgb_to_bayer_dvp.sv
// RGB888 stream to BGGR Bayer bytes with DVP frame timing (vsync/href/blanking).
// Define BAYER_TPG_EN to add the tpg_en input and an internal colour-bar pattern source.
module rgb_to_bayer_dvp
  import dvp_pkg::*;
#(
  parameter int IM_X   = 1280,
  parameter int IM_Y   = 720,
  parameter int VS_LEN = 8,
  parameter int VBP    = 16,
  parameter int VFP    = 16,
  parameter int HBLANK = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic       in_sof,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       out_ready,
`ifdef BAYER_TPG_EN
  input  logic       tpg_en,
`endif
  output logic [7:0] raw_data,
  output logic       data_valid,
  output logic       href,
  output logic       vsync,
  output logic       sof,
  output logic       eol,
  output logic       sync_err
);

  localparam int XW = $clog2(IM_X + 1);
  localparam int YW = $clog2(IM_Y + 1);

  dvp_state_e    state;
  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;

  logic       at_origin, fire, discard, advance;
  logic [7:0] pix_r, pix_g, pix_b;

  logic [7:0] raw_data_q, raw_data_d;
  logic       data_valid_q, data_valid_d;
  logic       href_q, href_d;
  logic       vsync_q, vsync_d;
  logic       sof_q, sof_d;
  logic       eol_q, eol_d;
  logic       sync_err_q, sync_err_d;

  assign at_origin = (cnt_x == '0) && (cnt_y == '0);

`ifdef BAYER_TPG_EN
  localparam int BAR_W = (IM_X >= NUM_BARS) ? IM_X / NUM_BARS : 1;

  logic        tpg_mode_q, tpg_mode_d;
  logic        gen;
  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;

  // First VSYNC cycle is the only point where the source mode may change.
  assign tpg_mode_d = ((state == S_VSYNC) && !vsync_q) ? tpg_en : tpg_mode_q;
  assign in_ready   = (state == S_ACTIVE) && out_ready && !tpg_mode_q;
  assign gen        = (state == S_ACTIVE) && out_ready && tpg_mode_q;
  assign bar_idx    = 3'(cnt_x / XW'(BAR_W));
  assign bar_rgb    = bar_color(bar_idx);
  assign pix_r      = tpg_mode_q ? bar_rgb[23:16] : in_r;
  assign pix_g      = tpg_mode_q ? bar_rgb[15:8]  : in_g;
  assign pix_b      = tpg_mode_q ? bar_rgb[7:0]   : in_b;
  assign fire       = in_valid && in_ready;
  assign discard    = fire && at_origin && !in_sof;
  assign advance    = (fire && !discard) || gen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tpg_mode_q <= 1'b0;
    else        tpg_mode_q <= tpg_mode_d;
  end
`else
  assign in_ready = (state == S_ACTIVE) && out_ready;
  assign pix_r    = in_r;
  assign pix_g    = in_g;
  assign pix_b    = in_b;
  assign fire     = in_valid && in_ready;
  // Until the frame's in_sof pixel arrives, pixels at the origin are swallowed.
  assign discard  = fire && at_origin && !in_sof;
  assign advance  = fire && !discard;
`endif

  dvp_timing_gen #(
    .IM_X(IM_X), .IM_Y(IM_Y), .VS_LEN(VS_LEN), .VBP(VBP), .VFP(VFP), .HBLANK(HBLANK),
    .XW(XW), .YW(YW)
  ) u_timing (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(advance),
    .state  (state),
    .cnt_x  (cnt_x),
    .cnt_y  (cnt_y)
  );

  always_comb begin
    raw_data_d   = advance ? bayer_pick({cnt_y[0], cnt_x[0]}, pix_r, pix_g, pix_b) : 8'h00;
    data_valid_d = advance;
    sof_d        = advance && at_origin;
    eol_d        = advance && (cnt_x == XW'(IM_X - 1));
    // href holds through stalls but stays low until the line's first byte.
    href_d       = advance || ((state == S_ACTIVE) && href_q);
    vsync_d      = (state == S_VSYNC);
    sync_err_d   = fire && in_sof && !at_origin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_data_q   <= 8'h00;
      data_valid_q <= 1'b0;
      href_q       <= 1'b0;
      vsync_q      <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      raw_data_q   <= raw_data_d;
      data_valid_q <= data_valid_d;
      href_q       <= href_d;
      vsync_q      <= vsync_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign raw_data   = raw_data_q;
  assign data_valid = data_valid_q;
  assign href       = href_q;
  assign vsync      = vsync_q;
  assign sof        = sof_q;
  assign eol        = eol_q;
  assign sync_err   = sync_err_q;

endmodule
